// File: rtl/rnn_x_feeder.sv
// rnn_x_feeder
// Upstream stage of the RNN core. Packs a host byte stream little-endian into
// 32-bit input vectors, buffers them in a word FIFO, raises a start request to
// the core once enough words are buffered (or the sequence is complete), and
// hands out one vector per i_en pulse while the core is running.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (released synchronously upstream)
//   s_valid    host byte valid
//   s_ready    host byte accepted when s_valid & s_ready
//   s_data     host byte
//   s_last     final byte of the sequence
//   ready      registered start request to the core
//   busy       core busy; its falling edge in RUN ends the sequence
//   i_en       core requests the next vector
//   idata      current vector, stable between i_en pulses
//   step_cnt   vectors delivered in the current sequence (wraps at 2047)
//   underflow  sticky: i_en seen while the FIFO was empty
//
// Optional build macro: XF_UNDERFLOW_HOLD_EN
//   defined   -> idata keeps its previous value on underflow
//   undefined -> idata is forced to zero on underflow
module rnn_x_feeder #(
    parameter int DEPTH       = 16,
    parameter int START_WORDS = 4,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        ready,
    input  logic        busy,
    input  logic        i_en,
    output logic [31:0] idata,
    output logic [10:0] step_cnt,
    output logic        underflow
);

    typedef enum logic [1:0] {IDLE, FILL, ARM, RUN} state_t;

    localparam logic [AW:0] START_CNT = (AW + 1)'(START_WORDS);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    state_t      state_reg, state_next;
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] count;
    logic [31:0] mem [DEPTH];
    logic [31:0] word_reg, word_next;
    logic [1:0]  lane_reg;
    logic        seq_done_reg;
    logic        busy_d_reg;
    logic        ready_reg;
    logic [31:0] idata_reg;
    logic [10:0] step_cnt_reg;
    logic        underflow_reg;

    logic full, empty, accept, push, pop, starve, flush;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign count = wr_ptr_reg - rd_ptr_reg;

    // Bytes are taken in every state until the sequence is closed or the FIFO
    // fills; a full FIFO blocks every byte, so a completing byte never drops.
    assign s_ready = !seq_done_reg && !full;
    assign accept  = s_valid && s_ready;

    // word_reg only ever holds the lanes below lane_reg, so upper lanes of a
    // partial word pushed by s_last are already zero.
    assign word_next = word_reg | ({24'd0, s_data} << {lane_reg, 3'b000});

    // Falling busy while running ends the sequence and overrides everything
    // else happening in that cycle.
    assign flush  = (state_reg == RUN) && busy_d_reg && !busy;
    assign push   = accept && ((lane_reg == 2'd3) || s_last) && !flush;
    assign pop    = (state_reg == RUN) && i_en && !empty && !flush;
    assign starve = (state_reg == RUN) && i_en && empty && !flush;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = FILL;
            FILL: if ((count >= START_CNT) || seq_done_reg) state_next = ARM;
            ARM:  if (busy) state_next = RUN;
            RUN:  if (flush) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            word_reg      <= '0;
            lane_reg      <= '0;
            seq_done_reg  <= 1'b0;
            busy_d_reg    <= 1'b0;
            ready_reg     <= 1'b0;
            idata_reg     <= '0;
            step_cnt_reg  <= '0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            busy_d_reg <= busy;
            ready_reg  <= (state_next == ARM);
            if (flush) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                word_reg      <= '0;
                lane_reg      <= '0;
                seq_done_reg  <= 1'b0;
                step_cnt_reg  <= '0;
                underflow_reg <= 1'b0;
            end else begin
                if (accept) begin
                    if (push) begin
                        word_reg   <= '0;
                        lane_reg   <= '0;
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                        if (s_last) seq_done_reg <= 1'b1;
                    end else begin
                        word_reg <= word_next;
                        lane_reg <= lane_reg + 2'd1;
                    end
                end
                if (pop) begin
                    idata_reg    <= mem[rd_ptr_reg[AW-1:0]];
                    rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
                    step_cnt_reg <= step_cnt_reg + 11'd1;
                end else if (starve) begin
`ifdef XF_UNDERFLOW_HOLD_EN
                    idata_reg <= idata_reg;
`else
                    idata_reg <= '0;
`endif
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= word_next;
    end

    assign ready     = ready_reg;
    assign idata     = idata_reg;
    assign step_cnt  = step_cnt_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_rnn_x_feeder.sv
// Testbench for rnn_x_feeder: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based reference model.
module tb_rnn_x_feeder;

    localparam int DEPTH       = 16;
    localparam int START_WORDS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        busy = 1'b0;
    logic        i_en = 1'b0;
    logic        s_ready, ready, underflow;
    logic [31:0] idata;
    logic [10:0] step_cnt;

    always #5 clk = ~clk;

    rnn_x_feeder #(.DEPTH(DEPTH), .START_WORDS(START_WORDS)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .ready(ready), .busy(busy),
        .i_en(i_en), .idata(idata), .step_cnt(step_cnt), .underflow(underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: word queue, pending byte list, and a phase number
    // (0 idle, 1 filling, 2 armed, 3 running).
    logic [31:0] m_q[$];
    logic [7:0]  m_pend[$];
    bit          m_done;
    int          m_phase;
    logic [31:0] m_idata;
    int          m_step;
    bit          m_uf;
    bit          m_busy_prev;
    bit          pre_sready;

    function automatic bit m_sready();
        return !m_done && (m_q.size() < DEPTH);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_pend.delete();
        m_done = 0; m_phase = 0; m_idata = 0; m_step = 0; m_uf = 0; m_busy_prev = 0;
    endtask

    task automatic m_edge(input bit v, input logic [7:0] d, input bit l, input bit b, input bit ie);
        int nphase;
        bit acc;
        logic [31:0] w;
        nphase = m_phase;
        if (m_phase == 3 && m_busy_prev && !b) begin
            m_q.delete(); m_pend.delete();
            m_done = 0; m_step = 0; m_uf = 0; nphase = 0;
            $display("seq end: flush");
        end else begin
            acc = v && m_sready();
            case (m_phase)
                0: if (acc) nphase = 1;
                1: if (m_q.size() >= START_WORDS || m_done) nphase = 2;
                2: if (b) nphase = 3;
                default: ;
            endcase
            if (m_phase == 3 && ie) begin
                if (m_q.size() > 0) begin
                    m_idata = m_q.pop_front();
                    m_step  = (m_step + 1) % 2048;
                    $display("pop  word 0x%08h step %0d", m_idata, m_step);
                end else begin
                    m_uf = 1;
`ifndef XF_UNDERFLOW_HOLD_EN
                    m_idata = 0;
`endif
                    $display("pop  underflow");
                end
            end
            if (acc) begin
                m_pend.push_back(d);
                if (m_pend.size() == 4 || l) begin
                    w = 0;
                    for (int k = 0; k < m_pend.size(); k++) w[8*k +: 8] = m_pend[k];
                    m_q.push_back(w);
                    m_pend.delete();
                    if (l) m_done = 1;
                    $display("push word 0x%08h level %0d", w, m_q.size());
                end
            end
        end
        m_phase = nphase;
        m_busy_prev = b;
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit b, input bit ie);
        @(negedge clk);
        s_valid = v; s_data = d; s_last = l; busy = b; i_en = ie;
        pre_sready = s_ready;
        @(posedge clk);
        #1;
        m_edge(v, d, l, b, ie);
        check_eq("s_ready", s_ready, m_sready());
        check_eq("ready", ready, (m_phase == 2));
        check_eq("idata", idata, m_idata);
        check_eq("step_cnt", step_cnt, m_step);
        check_eq("underflow", underflow, m_uf);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        s_valid = 0; s_last = 0; busy = 0; i_en = 0;
        #1;
        check_eq({tag, "_s_ready"}, s_ready, 1);
        check_eq({tag, "_ready"}, ready, 0);
        check_eq({tag, "_idata"}, idata, 0);
        check_eq({tag, "_step_cnt"}, step_cnt, 0);
        check_eq({tag, "_underflow"}, underflow, 0);
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_armed(input string tag);
        for (int i = 0; i < 20 && m_phase != 2; i++) cyc(0, 8'd0, 0, 0, 0);
        check_eq({tag, "_ready"}, ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit rb, v, l, ie;
        logic [31:0] prev;
        m_reset();
        do_reset("por");

        // Four full words, no s_last: arm on the count threshold.
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++) cyc(1, 8'(8'h11 * (k + 1)), 0, 0, 0);
        wait_armed("t1");
        cyc(0, 8'd0, 0, 1, 0);
        check_eq("t1_ready_low", ready, 0);
        cyc(0, 8'd0, 0, 1, 1);
        check_eq("t1_idata", idata, 32'h44332211);
        check_eq("t1_step", step_cnt, 1);
        cyc(0, 8'd0, 0, 0, 0);
        check_eq("t1_flush_step", step_cnt, 0);

        // Six bytes closed by s_last: early arm, partial word, then underflow.
        for (int i = 1; i <= 6; i++) cyc(1, 8'(i), (i == 6), 0, 0);
        check_eq("t2_s_ready_low", s_ready, 0);
        wait_armed("t2");
        cyc(0, 8'd0, 0, 1, 0);
        cyc(0, 8'd0, 0, 1, 1);
        check_eq("t2_word0", idata, 32'h04030201);
        cyc(0, 8'd0, 0, 1, 1);
        check_eq("t2_word1", idata, 32'h00000605);
        cyc(0, 8'd0, 0, 1, 1);
        check_eq("t2_underflow", underflow, 1);
`ifdef XF_UNDERFLOW_HOLD_EN
        check_eq("t2_uf_idata", idata, 32'h00000605);
`else
        check_eq("t2_uf_idata", idata, 32'h00000000);
`endif
        cyc(0, 8'd0, 0, 0, 0);
        check_eq("t2_uf_clear", underflow, 0);
        check_eq("t2_s_ready_back", s_ready, 1);

        // Overfill: 80 bytes offered with no pops, only 64 may be taken.
        acc = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0);
            acc += int'(pre_sready);
        end
        check_eq("t3_accepted", acc, 64);
        check_eq("t3_s_ready_full", s_ready, 0);
        wait_armed("t3");
        cyc(0, 8'd0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 8'd0, 0, 1, 1);
        check_eq("t3_step", step_cnt, DEPTH);
        cyc(0, 8'd0, 0, 0, 0);

        // Abort with three words still buffered, then a clean sequence.
        for (int i = 0; i < 20; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0);
        wait_armed("t4");
        cyc(0, 8'd0, 0, 1, 0);
        cyc(0, 8'd0, 0, 1, 1);
        cyc(0, 8'd0, 0, 1, 1);
        cyc(0, 8'd0, 0, 0, 0);
        check_eq("t4_step_clear", step_cnt, 0);
        check_eq("t4_s_ready", s_ready, 1);
        for (int k = 0; k < 4; k++) cyc(1, 8'(8'hA1 + k), (k == 3), 0, 0);
        wait_armed("t4b");
        cyc(0, 8'd0, 0, 1, 0);
        cyc(0, 8'd0, 0, 1, 1);
        check_eq("t4_fresh_word", idata, 32'hA4A3A2A1);
        cyc(0, 8'd0, 0, 0, 0);

        // Randomized traffic, including busy pulses while idle/filling.
        rb = 0;
        for (int i = 0; i < 600; i++) begin
            v  = bit'($urandom_range(0, 1));
            l  = ($urandom_range(0, 23) == 0);
            ie = ($urandom_range(0, 2) == 0);
            if (m_phase == 2) rb = bit'($urandom_range(0, 1));
            else if (m_phase == 3) begin
                if ($urandom_range(0, 24) == 0) rb = 0;
            end else rb = ($urandom_range(0, 9) == 0);
            cyc(v, 8'($urandom_range(0, 255)), l, rb, ie);
        end
        cyc(0, 8'd0, 0, 0, 0);
        cyc(0, 8'd0, 0, 0, 0);

        // Reset in the middle of a word, then a fresh word must form.
        do_reset("pre");
        cyc(1, 8'hEE, 0, 0, 0);
        cyc(1, 8'hDD, 0, 0, 0);
        do_reset("mid_word");
        for (int k = 0; k < 4; k++) cyc(1, 8'(8'h51 + k), (k == 3), 0, 0);
        wait_armed("t6");
        cyc(0, 8'd0, 0, 1, 0);
        prev = 32'h54535251;
        cyc(0, 8'd0, 0, 1, 1);
        check_eq("t6_fresh_word", idata, prev);
        cyc(0, 8'd0, 0, 1, 0);
        do_reset("mid_run");
        cyc(0, 8'd0, 0, 0, 0);
        cyc(1, 8'h77, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rnn_x_feeder.md
Name: rnn_x_feeder

Overview:
- Upstream stage of the RNN core: accepts a host byte stream, packs bytes into 32-bit input vectors x[t] and buffers them in a word FIFO.
- Drives the core's `ready` start strobe and its `idata` input.
- Advances to the next vector on each `i_en` pulse from the core; one input sequence is handled at a time.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words (power of 2, ≥4).
- START_WORDS, 4, FIFO words buffered before `ready` is raised; `s_last` overrides it.
- AW, $clog2(DEPTH), FIFO pointer width (derived).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous active-low reset.
- s_valid  in  1  host byte valid.
- s_ready  out  1  host byte accepted when `s_valid & s_ready`.
- s_data  in  8  host byte.
- s_last  in  1  marks the final byte of the sequence.
- ready  out  1  start request to the RNN core.
- busy  in  1  core busy.
- i_en  in  1  core requests the next x vector.
- idata  out  32  current x vector, held stable between `i_en` pulses.
- step_cnt  out  11  vectors delivered in the current sequence.
- underflow  out  1  sticky: `i_en` arrived while the FIFO was empty.

Behaviour:
- Reset (async assert, sync release) and after reset, every output is 0 except `s_ready`, which is 1:
  - FIFO empty, byte lane = 0, state IDLE.
- Packing:
  - Byte k of a word goes to bits [8k+7:8k], little-endian.
  - The 4th accepted byte pushes the word into the FIFO on the same edge.
  - `s_last` on a byte pushes the partial word immediately, upper lanes zero, and sets `seq_done`.
- `s_ready` = (state IDLE or FILL) & !`seq_done` & FIFO not full.
  - If a push completes while the FIFO is full, the byte is not accepted; `s_ready` already guarantees this.
- States:
  - IDLE: nothing pending. First accepted byte → FILL.
  - FILL: accumulate. Go to ARM when (FIFO count ≥ START_WORDS) or `seq_done`.
  - ARM: `ready` = 1 (registered). On `busy` = 1 → RUN, with `ready` = 0 the next cycle.
    - Host bytes continue to be accepted in ARM/RUN while `!seq_done` and the FIFO is not full; `s_ready` follows the same expression extended to ARM/RUN.
  - RUN: on `i_en` = 1 at edge N, pop the FIFO head into `idata` at edge N (visible from N+1) and increment `step_cnt` (wraps at 2047).
    - Pop and push in the same cycle are both performed; count is unchanged.
    - On `busy` falling (1 → 0): flush FIFO, clear byte lane, `seq_done`, `step_cnt`; keep `idata`; → IDLE.
- Underflow: `i_en` with the FIFO empty → `idata` = 0 (default build), `underflow` set.
  - `underflow` stays set until reset or return to IDLE.
- `i_en` outside RUN is ignored.
- `busy` rising in IDLE/FILL is ignored.
- Reset asserted mid-sequence: immediate return to the reset state; no partial word survives.
- FIFO: registered read, pointers AW+1 bits wide. Full = MSBs differ and LSBs equal; empty = pointers equal.

Optional Feature:
- XF_UNDERFLOW_HOLD_EN.
  - Defined: on underflow, `idata` keeps its previous value instead of becoming 0; `underflow` still sets.
  - Undefined: `idata` is forced to 0 on underflow, as above.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 ×4 words, no `s_last` → `ready` high after 4th word; raise `busy` → `ready` low the next cycle; `i_en` → `idata` = 0x44332211 one cycle later, `step_cnt` = 1.
- 6 bytes 01..06 with `s_last` on 06 → FIFO holds 0x04030201, 0x00000605; `ready` rises despite count 2 < START_WORDS; `s_ready` low after `s_last`.
- DEPTH = 16: stream 80 bytes while the core never pops → `s_ready` drops after 64 bytes; no word lost or overwritten.
- RUN with 2 words, 3 `i_en` pulses → third gives `idata` = 0 (or the previous word with XF_UNDERFLOW_HOLD_EN) and `underflow` = 1.
- Drop `busy` with 3 words left → FIFO empty, `step_cnt` = 0, state IDLE, `s_ready` = 1; next sequence starts clean.
- Assert reset low mid-word (2 bytes into lane) and mid-RUN → all outputs at reset values immediately; after release the first 4 bytes form a fresh word.
